// File: rtl/player_pkg.sv
// Shared definitions for the player instruction channel: opcodes, move
// directions, instruction packing and the arbiter state encoding.
package player_pkg;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Instruction word layout: {op, arg, 4'b0000}
    function automatic logic [15:0] pack_instr(input logic [3:0] op, input logic [7:0] arg);
        return {op, arg, 4'b0000};
    endfunction

    // 8-bit add clamped at 255
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/player_instr_arbiter_if.sv
// Player instruction channel: instruction word with valid/ready handshake.
// The arbiter drives it through the master modport, the player datapath
// consumes it through the slave modport.
interface player_instr_arbiter_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/dmg_event_fifo.sv
// Damage/heal event queue. Entries are {heal, val}. A flush empties the
// queue and discards a same-cycle push. Full status comes from the
// registered count, and drop is a registered one-cycle pulse.
// Optional DMG_COALESCE_EN: a damage push onto a damage tail adds into the
// tail (saturating at 255) instead of taking a new entry.
module dmg_event_fifo
    import player_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       push_heal,
    input  logic [7:0] push_val,
    input  logic       pop,
    output logic       empty,
    output logic       full,
    output logic       head_heal,
    output logic [7:0] head_val,
    output logic       drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tail_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic          do_pop, do_push, merge, wr_en;
    logic [AW-1:0] wr_idx;
    logic [8:0]    wr_data;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign head_heal = mem_q[rd_ptr_q][8];
    assign head_val  = mem_q[rd_ptr_q][7:0];
    assign drop      = drop_q;

    // Decide pop/push/merge/drop for this cycle and the next pointer state
    always_comb begin
        do_pop   = pop && !empty && !flush;
        tail_ptr = wr_ptr_q - AW'(1);
`ifdef DMG_COALESCE_EN
        // Never merge into the single entry that is leaving this cycle
        merge = push && !flush && !push_heal && !empty && !mem_q[tail_ptr][8]
                && !(do_pop && count_q == CW'(1));
`else
        merge = 1'b0;
`endif
        // A full queue still accepts when the same cycle frees a slot
        do_push = push && !flush && !merge && (!full || do_pop);
        drop_d  = push && !merge && !do_push;

        wr_en   = merge || do_push;
        wr_idx  = merge ? tail_ptr : wr_ptr_q;
        wr_data = merge ? {1'b0, sat_add8(mem_q[tail_ptr][7:0], push_val)}
                        : {push_heal, push_val};

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Pointer, count and drop-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: rtl/player_instr_arbiter.sv
// Arbitrates the single player instruction channel between set-HP,
// queued damage/heal events and rate-limited movement.
// Fixed priority: SHP > damage/heal queue > MOV. A selected instruction is
// held until accepted, then the FSM spends at least one cycle in IDLE.
// Optional DMG_COALESCE_EN (inside dmg_event_fifo) merges consecutive damage.
module player_instr_arbiter
    import player_pkg::*;
#(
    parameter int DMG_DEPTH = 4,
    parameter int MOVE_GAP  = 4,
    parameter int HEAL_AMT  = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   shp_req,
    input  logic [7:0]             shp_val,
    input  logic                   dmg_valid,
    input  logic                   dmg_heal,
    input  logic [7:0]             dmg_val,
    input  logic                   mov_req,
    input  logic [1:0]             mov_dir,
    player_instr_arbiter_if.master bus,
    output logic                   start_dmg,
    output logic                   dmg_full,
    output logic                   dmg_drop
);

    localparam int CDW = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [CDW-1:0] CD_LOAD  = CDW'(MOVE_GAP - 1);
    localparam logic [7:0]     HEAL_ARG = 8'(HEAL_AMT);

    arb_state_e     state_q, state_d;
    logic [15:0]    instr_q, instr_d;
    logic [CDW-1:0] cd_q, cd_d;
    logic           shp_pend_q, shp_pend_d;
    logic [7:0]     shp_val_q, shp_val_d;
    logic           start_q, start_d;

    logic           fifo_pop, fifo_empty, fifo_head_heal;
    logic [7:0]     fifo_head_val;
    logic [3:0]     hold_op;

    assign hold_op         = instr_q[15:12];
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == HOLD);
    assign start_dmg       = start_q;

    dmg_event_fifo #(
        .DEPTH (DMG_DEPTH)
    ) u_dmg_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (dmg_valid),
        .push_heal (dmg_heal),
        .push_val  (dmg_val),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .full      (dmg_full),
        .head_heal (fifo_head_heal),
        .head_val  (fifo_head_val),
        .drop      (dmg_drop)
    );

    // Next-state: priority select in IDLE, handshake completion in HOLD
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        start_d    = 1'b0;
        cd_d       = (cd_q == '0) ? '0 : cd_q - CDW'(1);
        shp_pend_d = shp_pend_q || shp_req;
        shp_val_d  = shp_req ? shp_val : shp_val_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                instr_d = '0;
                // A same-cycle shp_req is served directly; flush never cancels SHP
                if (shp_pend_q || shp_req) begin
                    instr_d    = pack_instr(OP_SHP, shp_req ? shp_val : shp_val_q);
                    shp_pend_d = 1'b0;
                    state_d    = HOLD;
                end else if (!flush && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    instr_d  = fifo_head_heal ? pack_instr(OP_HPY, HEAL_ARG)
                                              : pack_instr(OP_DPY, fifo_head_val);
                    state_d  = HOLD;
                end else if (!flush && mov_req && cd_q == '0) begin
                    instr_d = pack_instr(OP_MOV, {6'b0, mov_dir});
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    state_d = IDLE;
                    instr_d = '0;
                    start_d = (hold_op == OP_DPY) || (hold_op == OP_HPY);
                    if (hold_op == OP_MOV) begin
                        cd_d = CD_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            cd_q       <= '0;
            shp_pend_q <= 1'b0;
            shp_val_q  <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            cd_q       <= cd_d;
            shp_pend_q <= shp_pend_d;
            shp_val_q  <= shp_val_d;
            start_q    <= start_d;
        end
    end

endmodule

// File: tb/tb_player_instr_arbiter.sv
// Self-checking bench for player_instr_arbiter: directed scenarios with
// literal expectations, then randomized traffic compared every cycle
// against a queue-based model of the arbitration rules.
module tb_player_instr_arbiter;
    import player_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int HEAL  = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       shp_req = 1'b0;
    logic [7:0] shp_val = '0;
    logic       dmg_valid = 1'b0;
    logic       dmg_heal = 1'b0;
    logic [7:0] dmg_val = '0;
    logic       mov_req = 1'b0;
    logic [1:0] mov_dir = '0;
    logic       instr_ready = 1'b0;
    logic       start_dmg, dmg_full, dmg_drop;

    player_instr_arbiter_if bus();
    assign bus.instr_ready = instr_ready;

    player_instr_arbiter #(
        .DMG_DEPTH (DEPTH),
        .MOVE_GAP  (GAP),
        .HEAL_AMT  (HEAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .shp_req   (shp_req),
        .shp_val   (shp_val),
        .dmg_valid (dmg_valid),
        .dmg_heal  (dmg_heal),
        .dmg_val   (dmg_val),
        .mov_req   (mov_req),
        .mov_dir   (mov_dir),
        .bus       (bus),
        .start_dmg (start_dmg),
        .dmg_full  (dmg_full),
        .dmg_drop  (dmg_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue entries: 0..255 = damage amount, 256 = heal.
    int m_q[$];
    bit m_hold  = 0;
    int m_instr = 0;
    bit m_pend  = 0;
    int m_pval  = 0;
    int m_cd    = 0;
    bit m_start = 0;
    bit m_drop  = 0;
    int m_e, m_op, m_cd_next, m_sum;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_hold = 0; m_instr = 0; m_pend = 0; m_pval = 0;
            m_cd = 0; m_start = 0; m_drop = 0;
        end else begin
            m_start   = 0;
            m_drop    = 0;
            m_cd_next = (m_cd > 0) ? m_cd - 1 : 0;
            if (m_hold) begin
                if (instr_ready) begin
                    m_op    = m_instr / 4096;
                    m_hold  = 0;
                    m_start = (m_op == 1 || m_op == 2);
                    if (m_op == 5) m_cd_next = GAP - 1;
                end
                if (shp_req) begin
                    m_pend = 1;
                    m_pval = shp_val;
                end
            end else begin
                if (m_pend || shp_req) begin
                    m_instr = 6 * 4096 + (shp_req ? int'(shp_val) : m_pval) * 16;
                    m_pend  = 0;
                    m_hold  = 1;
                end else if (!flush && m_q.size() > 0) begin
                    m_e     = m_q.pop_front();
                    m_instr = (m_e == 256) ? (1 * 4096 + HEAL * 16) : (2 * 4096 + m_e * 16);
                    m_hold  = 1;
                end else if (!flush && mov_req && m_cd == 0) begin
                    m_instr = 5 * 4096 + int'(mov_dir) * 16;
                    m_hold  = 1;
                end
            end
            if (flush) begin
                m_q.delete();
                if (dmg_valid) m_drop = 1;
            end else if (dmg_valid) begin
`ifdef DMG_COALESCE_EN
                if (!dmg_heal && m_q.size() > 0 && m_q[m_q.size()-1] != 256) begin
                    m_sum = m_q[m_q.size()-1] + int'(dmg_val);
                    m_q[m_q.size()-1] = (m_sum > 255) ? 255 : m_sum;
                end else
`endif
                if (m_q.size() < DEPTH) m_q.push_back(dmg_heal ? 256 : int'(dmg_val));
                else m_drop = 1;
            end
            m_cd = m_cd_next;
        end
    end

    // ---------------- per-cycle comparison ----------------
    int start_cnt = 0;
    int drop_cnt  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("instr_valid", int'(bus.instr_valid), 0);
            check("instr", int'(bus.instr), 0);
            check("start_dmg", int'(start_dmg), 0);
            check("dmg_full", int'(dmg_full), 0);
            check("dmg_drop", int'(dmg_drop), 0);
        end else begin
            check("instr_valid", int'(bus.instr_valid), int'(m_hold));
            check("instr", int'(bus.instr), m_hold ? m_instr : 0);
            check("start_dmg", int'(start_dmg), int'(m_start));
            check("dmg_full", int'(dmg_full), int'(m_q.size() == DEPTH));
            check("dmg_drop", int'(dmg_drop), int'(m_drop));
            start_cnt += int'(start_dmg);
            drop_cnt  += int'(dmg_drop);
        end
    end

    // ---------------- accepted-instruction log ----------------
    int acc_q[$];
    int acc_cyc[$];
    int cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && bus.instr_valid && instr_ready) begin
            acc_q.push_back(int'(bus.instr));
            acc_cyc.push_back(cyc);
            $display("accept instr=0x%04h cycle %0d", bus.instr, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        acc_cyc.delete();
        start_cnt = 0;
        drop_cnt  = 0;
    endtask

    task automatic dmg_pulse(input logic heal, input logic [7:0] val);
        dmg_valid = 1'b1;
        dmg_heal  = heal;
        dmg_val   = val;
        tick();
        dmg_valid = 1'b0;
        dmg_heal  = 1'b0;
    endtask

    logic [1:0] dirs [4];
    int n_mov, prev_cyc;

    initial begin
        dirs[0] = DIR_UP; dirs[1] = DIR_LEFT; dirs[2] = DIR_DOWN; dirs[3] = DIR_RIGHT;

        // Reset state
        repeat (3) tick();
        check("rst_instr_valid", int'(bus.instr_valid), 0);
        check("rst_instr", int'(bus.instr), 0);
        check("rst_start_dmg", int'(start_dmg), 0);
        check("rst_dmg_full", int'(dmg_full), 0);
        check("rst_dmg_drop", int'(dmg_drop), 0);
        rst_n = 1'b1;
        tick();

        // Set-HP issued one cycle after request, no start_dmg
        clear_logs();
        instr_ready = 1'b1;
        shp_req = 1'b1; shp_val = 8'd100;
        tick();
        shp_req = 1'b0;
        check("shp_valid_latency", int'(bus.instr_valid), 1);
        check("shp_instr", int'(bus.instr), 'h6640);
        repeat (4) tick();
        check("shp_accept_count", acc_q.size(), 1);
        if (acc_q.size() >= 1) check("shp_accept_word", acc_q[0], 'h6640);
        check("shp_no_start", start_cnt, 0);

        // Fill the queue behind a held SHP: four kept, one dropped
        clear_logs();
        instr_ready = 1'b0;
        shp_req = 1'b1; shp_val = 8'd100;
        tick();
        shp_req = 1'b0;
        for (int i = 0; i < 5; i++) dmg_pulse(1'b0, 8'd3);
        repeat (2) tick();
        check("fill_full", int'(dmg_full), 1);
        check("fill_drop_count", drop_cnt, 1);
        instr_ready = 1'b1;
        repeat (20) tick();
        check("fill_accept_count", acc_q.size(), 5);
        for (int i = 1; i < acc_q.size(); i++) check("fill_dpy_word", acc_q[i], 'h2030);
        check("fill_start_count", start_cnt, 4);
        check("fill_not_full", int'(dmg_full), 0);

        // Priority order SHP > heal > MOV
        clear_logs();
        shp_req = 1'b1; shp_val = 8'd100;
        dmg_valid = 1'b1; dmg_heal = 1'b1; dmg_val = 8'd77;
        mov_req = 1'b1; mov_dir = DIR_RIGHT;
        tick();
        shp_req = 1'b0; dmg_valid = 1'b0; dmg_heal = 1'b0;
        for (int i = 0; i < 20 && acc_q.size() < 3; i++) tick();
        mov_req = 1'b0;
        repeat (8) tick();
        check("prio_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("prio_first_shp", acc_q[0], 'h6640);
            check("prio_second_hpy", acc_q[1], 'h10A0);
            check("prio_third_mov", acc_q[2], 'h5030);
        end

        // Movement rate limit
        clear_logs();
        mov_req = 1'b1; mov_dir = DIR_LEFT;
        repeat (40) tick();
        mov_req = 1'b0;
        repeat (6) tick();
        n_mov = 0;
        prev_cyc = -1000;
        for (int i = 0; i < acc_q.size(); i++) begin
            check("mov_word", acc_q[i], 'h5010);
            if (n_mov > 0) check("mov_gap_ok", int'((acc_cyc[i] - prev_cyc) >= GAP), 1);
            prev_cyc = acc_cyc[i];
            n_mov++;
        end
        check("mov_enough_issues", int'(n_mov >= 6), 1);

        // Flush during HOLD of first damage
        clear_logs();
        instr_ready = 1'b0;
        dmg_pulse(1'b0, 8'd5);
        dmg_pulse(1'b0, 8'd6);
        dmg_pulse(1'b0, 8'd7);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        instr_ready = 1'b1;
        repeat (12) tick();
        check("flush_count", acc_q.size(), 1);
        if (acc_q.size() >= 1) check("flush_first_done", acc_q[0], 'h2050);
        check("flush_start_count", start_cnt, 1);

`ifdef DMG_COALESCE_EN
        // Consecutive damage merges and saturates
        clear_logs();
        instr_ready = 1'b0;
        shp_req = 1'b1; shp_val = 8'd1;
        tick();
        shp_req = 1'b0;
        dmg_pulse(1'b0, 8'd200);
        dmg_pulse(1'b0, 8'd100);
        tick();
        instr_ready = 1'b1;
        repeat (10) tick();
        check("coal_count", acc_q.size(), 2);
        if (acc_q.size() == 2) check("coal_word", acc_q[1], 'h2FF0);
`endif

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 2000; i++) begin
            flush       = ($urandom_range(0, 39) == 0);
            shp_req     = ($urandom_range(0, 29) == 0);
            shp_val     = 8'($urandom_range(0, 255));
            dmg_valid   = ($urandom_range(0, 2) == 0);
            dmg_heal    = ($urandom_range(0, 3) == 0);
            dmg_val     = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) mov_req = ~mov_req;
            mov_dir     = dirs[$urandom_range(0, 3)];
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        flush = 1'b0; shp_req = 1'b0; dmg_valid = 1'b0; mov_req = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
